// File: rtl/booth_radix4_seq_multiplier.sv
// booth_radix4_seq_multiplier: sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Operands are extended by two bits at capture so signed and unsigned share one datapath.
module booth_radix4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [XW-1:0]      mx_q, mx_d, qx_q, qx_d;
  logic               qm1_q, qm1_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [XW-1:0]      m_ext, q_ext;
  logic [AW-1:0]      mx_a, mx2, pp, sum;
  logic [2:0]         trip;
  logic               accept;
  assign m_ext  = {{2{signed_mode & m[WIDTH-1]}}, m};
  assign q_ext  = {{2{signed_mode & q[WIDTH-1]}}, q};
  assign mx_a   = {{2{mx_q[XW-1]}}, mx_q};
  assign mx2    = mx_a << 1;
  assign trip   = {qx_q[1:0], qm1_q};
  assign pp     = (trip == 3'b001 || trip == 3'b010) ? mx_a :
                  (trip == 3'b011) ? mx2 :
                  (trip == 3'b100) ? -mx2 :
                  (trip == 3'b101 || trip == 3'b110) ? -mx_a : '0;
  assign sum    = acc_q + pp;
  assign accept = start && (state_q != RUN);
  // RUN holds N+1 cycles: N Booth steps, then one cycle to move the product into p.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mx_d    = mx_q;
    qx_d    = qx_q;
    qm1_d   = qm1_q;
    acc_d   = acc_q;
    p_d     = p_q;
    if (accept) begin
      state_d = RUN;
      cnt_d   = CW'(N);
      mx_d    = m_ext;
      qx_d    = q_ext;
      qm1_d   = 1'b0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
        qx_d  = {sum[1:0], qx_q[XW-1:2]};
        qm1_d = qx_q[1];
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = DONE;
        p_d     = {acc_q[WIDTH-3:0], qx_q};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mx_q    <= '0;
      qx_q    <= '0;
      qm1_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mx_q    <= mx_d;
      qx_q    <= qx_d;
      qm1_q   <= qm1_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign p    = p_q;
endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// tb_booth_radix4_seq_multiplier: scoreboard bench driving a WIDTH=32 and a WIDTH=8 instance.
module tb_booth_radix4_seq_multiplier;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start32 = 1'b0, sm32 = 1'b0, busy32, done32;
  logic [31:0] m32 = '0, q32 = '0;
  logic [63:0] p32;
  logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] p8;
  logic [63:0] sb32[$];
  logic [63:0] sb8[$];
  logic [63:0] last32 = '0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  booth_radix4_seq_multiplier #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
    .m(m32), .q(q32), .busy(busy32), .done(done32), .p(p32));

  booth_radix4_seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .m(m8), .q(q8), .busy(busy8), .done(done8), .p(p8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: extend each operand to 64 bits and keep the low 2*w bits of the product.
  function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [63:0] lo, xa, xb, pr;
    lo = (w == 32) ? 64'hFFFF_FFFF : (64'd1 << w) - 64'd1;
    xa = {32'b0, a} & lo;
    xb = {32'b0, b} & lo;
    if (sm && xa[w-1]) xa = xa | ~lo;
    if (sm && xb[w-1]) xb = xb | ~lo;
    pr = xa * xb;
    return (w == 32) ? pr : pr & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic issue(input int w, input logic sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e);
    if (w == 32) begin
      start32 = 1'b1; sm32 = sm; m32 = a; q32 = b; sb32.push_back(e);
    end else begin
      start8 = 1'b1; sm8 = sm; m8 = a[7:0]; q8 = b[7:0]; sb8.push_back(e);
    end
  endtask

  // Called on the first negedge after the accepting edge (cycle 0).
  task automatic wait_done(input int w);
    int c = 0;
    while (!((w == 32) ? done32 : done8) && c < 40) begin
      if (c >= 1) chk((w == 32) ? "busy32" : "busy8", {63'b0, (w == 32) ? busy32 : busy8}, 64'd1);
      @(negedge clk);
      c++;
    end
    chk((w == 32) ? "latency32" : "latency8", 64'(c), 64'(w / 2 + 2));
  endtask

  task automatic op(input int w, input logic sm, input logic [31:0] a,
                    input logic [31:0] b, input logic [63:0] e);
    @(negedge clk);
    issue(w, sm, a, b, e);
    @(posedge clk);
    @(negedge clk);
    if (w == 32) begin
      start32 = 1'b0; sm32 = 1'($urandom); m32 = $urandom; q32 = $urandom;
    end else begin
      start8 = 1'b0; sm8 = 1'($urandom); m8 = 8'($urandom); q8 = 8'($urandom);
    end
    wait_done(w);
  endtask

  always @(negedge clk) begin
    if (done32) begin
      chk("busy_with_done32", {63'b0, busy32}, 64'd0);
      if (sb32.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done32_unexpected: got p=%h expected no done at %0t", p32, $time);
      end else begin
        last32 = sb32.pop_front();
        chk("p32", p32, last32);
      end
    end
    if (done8) begin
      chk("busy_with_done8", {63'b0, busy8}, 64'd0);
      if (sb8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done8_unexpected: got p=%h expected no done at %0t", p8, $time);
      end else begin
        chk("p8", {48'b0, p8}, sb8.pop_front());
      end
    end
  end

  initial begin
    logic        sm;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("rst_p32", p32, 64'd0);
    chk("rst_busy32", {63'b0, busy32}, 64'd0);
    chk("rst_done32", {63'b0, done32}, 64'd0);
    chk("rst_p8", {48'b0, p8}, 64'd0);
    reset_n = 1'b1;
    op(32, 1'b1, 32'd3, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFEB);
    op(32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    op(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    op(32, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op(32, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    repeat (3) @(negedge clk);
    chk("p32_held", p32, 64'hC000_0000_8000_0000);
    op(8, 1'b1, 32'h80, 32'h80, 64'h4000);
    op(8, 1'b0, 32'hFF, 32'hFF, 64'hFE01);
    op(8, 1'b1, 32'h00, 32'hFF, 64'h0000);
    for (int i = 0; i < 20; i++) begin
      sm = 1'($urandom); a = $urandom; b = $urandom;
      op(32, sm, a, b, ref_mul(sm, a, b, 32));
    end
    for (int i = 0; i < 12; i++) begin
      sm = 1'($urandom); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      op(8, sm, a, b, ref_mul(sm, a, b, 8));
    end
    // start held high: pair presented during RUN must be ignored, DONE cycle accepts 5 x 6
    @(negedge clk);
    issue(32, 1'b1, 32'd100, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FED4);
    @(posedge clk);
    @(negedge clk);
    m32 = 32'h1234_5678; q32 = 32'h0BAD_F00D; sm32 = 1'b0;
    wait_done(32);
    issue(32, 1'b0, 32'd5, 32'd6, 64'd30);
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    wait_done(32);
    // reset in RUN cycle 9 aborts the operation
    @(negedge clk);
    issue(32, 1'b0, 32'd3, 32'd4, 64'd12);
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb32.delete();
    chk("abort_busy", {63'b0, busy32}, 64'd0);
    chk("abort_done", {63'b0, done32}, 64'd0);
    chk("abort_p", p32, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_abort_p", p32, 64'd0);
    chk("post_abort_busy", {63'b0, busy32}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/booth_radix4_seq_multiplier.md
Name: booth_radix4_seq_multiplier

Overview:
- Sequential, parametrised radix-4 (modified) Booth multiplier for the ALU's MUL path.
- Multiplies two WIDTH-bit operands, signed or unsigned per operation, producing a 2*WIDTH-bit product.
- Retires two multiplier bits per clock with a start/busy/done handshake.
- Replaces the one-shot combinational multiplier so the datapath can hold the product registers (HI/LO) while the control unit waits on done.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4.
- Derived, not overridable: N = WIDTH/2 + 1, the iteration count.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on clk when not busy
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned
- m  input  WIDTH  multiplicand; captured when start is accepted
- q  input  WIDTH  multiplier; captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; product valid on p
- p  output  2*WIDTH  product; held until the next done

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, p=0; all internal registers cleared. Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 -> capture operands, go to RUN with count=N, busy=1.
  - RUN: one Booth step per cycle; count decrements each step; after the N-th step -> DONE.
  - DONE: p <= final product, done=1, busy=0 for exactly this cycle.
    - start=1 in DONE is accepted, with the same semantics as from IDLE, giving back-to-back operation.
    - Otherwise -> IDLE.
- Handshake: start is ignored while in RUN; operands are not re-sampled after capture.
- Latency: start accepted at edge k -> done high after edge k+N+1. For WIDTH=32 that is 18 cycles.
- Operand extension at capture: both operands are extended to WIDTH+2 bits, sign-extended if signed_mode=1, zero-extended otherwise. This makes unsigned operands exact.
- Booth step: examine triplet {q_ext[2i+1], q_ext[2i], q_ext[2i-1]}, with the implicit bit q_ext[-1]=0.
  - 000/111 -> 0
  - 001/010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101/110 -> -M
  - M is the extended multiplicand; the negative terms use the two's complement of the WIDTH+2-bit operand.
- Accumulator: at least WIDTH+4 bits, signed. Each step adds the selected partial product to the upper part, then arithmetic-shifts the {acc, q_ext} pair right by 2.
- Result: p = low 2*WIDTH bits of the full product.
  - Signed: exact for all inputs, including most-negative x most-negative.
  - Unsigned: exact for all inputs.
- signed_mode is captured with the operands; changing it mid-operation has no effect.
- done and busy are never high in the same cycle.
- p changes only on the DONE edge or on reset.

Test Plan:
- WIDTH=32, signed_mode=1, m=3, q=-7 (0xFFFFFFF9) -> done at cycle 18; p=0xFFFFFFFFFFFFFFEB (-21). Check busy high for cycles 1-17.
- WIDTH=32, m=q=0xFFFFFFFF:
  - signed -> p=0x0000000000000001.
  - unsigned -> p=0xFFFFFFFE00000001.
- WIDTH=32, signed, m=q=0x80000000 -> p=0x4000000000000000. Then 0x7FFFFFFF x 0x80000000 -> p=0xC000000080000000.
- Start held high throughout with a new operand pair presented during RUN -> the second pair is ignored until DONE. In DONE, start captures m=5, q=6 -> next done 18 cycles later with p=30, with no idle gap.
- Start 3 x 4, then pull reset_n low in RUN cycle 9 -> immediately busy=0, done=0, p=0. After release, no done pulse occurs until a new start.
- WIDTH=8 instance (N=5, done at cycle 6):
  - signed -128 x -128 -> p=0x4000.
  - unsigned 255 x 255 -> p=0xFE01.
  - signed 0 x -1 -> p=0x0000.
